dmem_arbiter: RTL

Shares the single-port data memory between two requesters: port 0 (CPU MEM stage) and port 1 (debug/DMA loader). Requests are arbitrated, registered, and driven onto the memory for exactly one access cycle. Each access returns a one-cycle response carrying read data or a write ack, plus an error flag for illegal addresses. The block sits between the requesters and the data memory, whose read and write ports are combinational.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arb_pick.sv | 51 +++++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_e;

    typedef logic port_id_t;

    localparam int unsigned DMEM_DEPTH_WORDS = 1024;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection for the two-port arbiter: round-robin or fixed priority
// with a starvation guard for port 1.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO   = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output port_id_t   winner_o
);

    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    port_id_t      last_grant_q;
    logic [CW-1:0] starve_q;
    port_id_t      winner;

    always_comb begin
        winner = port_id_t'(req_i[1] & ~req_i[0]);
        if (req_i == 2'b11) begin
            if (FIXED_PRIO != 0) begin
                winner = port_id_t'(starve_q == LIMIT);
            end else begin
                winner = ~last_grant_q;
            end
        end
    end

    assign winner_o = winner;

    // starve_q saturates at LIMIT; it only steers the tie case in fixed mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            starve_q     <= '0;
        end else if (take_i) begin
            last_grant_q <= winner;
            if (winner == 1'b1) begin
                starve_q <= '0;
            end else if (req_i[1] && (starve_q != LIMIT)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port combinational data memory:
// grant in IDLE, one registered access cycle, then a one-cycle response.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = DMEM_DEPTH_WORDS,
    parameter int unsigned FIXED_PRIO   = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    arb_state_e  state_q;
    port_id_t    port_q;
    port_id_t    winner;
    logic        we_q;
    logic        err_q;
    logic        mem_we_q;
    logic        mem_re_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        p0_rvalid_q;
    logic        p1_rvalid_q;
    logic        p0_err_q;
    logic        p1_err_q;
    logic [31:0] p0_rdata_q;
    logic [31:0] p1_rdata_q;

    logic        take;
    logic        sel_we;
    logic        sel_err;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] rd_word;

    // Grant is Mealy; qualifying with rst_n keeps gnt low throughout reset.
    assign take   = rst_n & (state_q == IDLE) & (p0_req | p1_req);
    assign p0_gnt = take & (winner == 1'b0);
    assign p1_gnt = take & (winner == 1'b1);

    dmem_arb_pick #(
        .FIXED_PRIO   (FIXED_PRIO),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({p1_req, p0_req}),
        .take_i   (take),
        .winner_o (winner)
    );

    always_comb begin
        sel_we    = (winner == 1'b1) ? p1_we    : p0_we;
        sel_addr  = (winner == 1'b1) ? p1_addr  : p0_addr;
        sel_wdata = (winner == 1'b1) ? p1_wdata : p0_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) ||
                    ({2'b00, sel_addr[31:2]} >= 32'(DEPTH_WORDS));
        rd_word   = (!we_q && !err_q) ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (take) begin
                        port_q      <= winner;
                        we_q        <= sel_we;
                        err_q       <= sel_err;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_we_q    <= sel_we & ~sel_err;
                        mem_re_q    <= ~sel_we & ~sel_err;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q    <= 1'b0;
                    mem_re_q    <= 1'b0;
                    p0_rvalid_q <= (port_q == 1'b0);
                    p1_rvalid_q <= (port_q == 1'b1);
                    p0_err_q    <= (port_q == 1'b0) & err_q;
                    p1_err_q    <= (port_q == 1'b1) & err_q;
                    p0_rdata_q  <= (port_q == 1'b0) ? rd_word : '0;
                    p1_rdata_q  <= (port_q == 1'b1) ? rd_word : '0;
                    state_q     <= RESP;
                end
                RESP: begin
                    p0_rvalid_q <= 1'b0;
                    p1_rvalid_q <= 1'b0;
                    p0_err_q    <= 1'b0;
                    p1_err_q    <= 1'b0;
                    p0_rdata_q  <= '0;
                    p1_rdata_q  <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule
